// File: rtl/io_uart.sv
// io_uart: full-duplex 8N1 UART responder on the 6-bit core I/O bus (TX FIFO, mid-bit RX, 16-bit divisor).
// Optional interrupt output is built only when IO_UART_IRQ_EN is defined.
module io_uart #(
    parameter logic [5:0]  BASE_ADDR     = 6'h08,
    parameter logic [15:0] DIV_RESET     = 16'd433,
    parameter int          TX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] io_addr,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef IO_UART_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h3;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Register file and address decode
    // ------------------------------------------------------------------
    logic [3:0]  ctrl;
    logic [15:0] div;
    logic [7:0]  rx_hold;
    logic        rxc;
    logic        rxovf;
    logic        ferr;

    logic [6:0]  addr_off;
    logic        addr_hit;
    logic [2:0]  reg_sel;
    logic        rd_data;
    logic        wr_data;
    logic        wr_status;
    logic        wr_ctrl;
    logic        wr_divl;
    logic        wr_divh;
    logic [7:0]  rd_mux;

    // Bus strobes are single-cycle and always accepted: there is no
    // wait state, reads are combinational and side effects land on the edge.
    assign addr_off  = {1'b0, io_addr} - {1'b0, BASE_ADDR};
    assign addr_hit  = (addr_off < 7'd5);
    assign reg_sel   = addr_off[2:0];
    assign rd_data   = io_re && addr_hit && (reg_sel == 3'd0);
    assign wr_data   = io_we && addr_hit && (reg_sel == 3'd0);
    assign wr_status = io_we && addr_hit && (reg_sel == 3'd1);
    assign wr_ctrl   = io_we && addr_hit && (reg_sel == 3'd2);
    assign wr_divl   = io_we && addr_hit && (reg_sel == 3'd3);
    assign wr_divh   = io_we && addr_hit && (reg_sel == 3'd4);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] fifo_wp;
    logic [AW-1:0] fifo_rp;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    assign fifo_full  = (fifo_cnt == CW'(TX_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // Fullness is judged on the pre-edge count, so a same-edge pop does not rescue a push.
    assign fifo_push  = wr_data && !fifo_full;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wp] <= io_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wp <= fifo_wp + AW'(1);
            end
            if (fifo_pop) begin
                fifo_rp <= fifo_rp + AW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX shifter FSM
    // ------------------------------------------------------------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        txd_q, txd_n;
    logic        txe;

    assign txe = fifo_empty && (tx_state == TX_IDLE);
    assign txd = txd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd_q    <= txd_n;
        end
    end

    // The period counter reloads from div at each bit boundary, so a divisor
    // write never stretches or shortens the bit already in flight.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (ctrl[0] && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_mem[fifo_rp];
                    tx_cnt_n   = div;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n   = div;
                    tx_bit_n   = 3'd0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n   = div;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == 16'd0) begin
                    if (ctrl[0] && !fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_n = fifo_mem[fifo_rp];
                        tx_cnt_n   = div;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_shift_n[0];
            default:  txd_n = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // RX synchronizer and mid-bit sampling FSM
    // ------------------------------------------------------------------
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_meta, rx_sync, rx_prev;
    logic        rx_fall;
    logic        rx_done;
    logic        rx_ferr;
    logic [16:0] div_p1;
    logic [15:0] half_bit;
    logic [15:0] half_m1;

    assign rx_fall  = rx_prev && !rx_sync;
    assign div_p1   = {1'b0, div} + 17'd1;
    assign half_bit = 16'(div_p1 >> 1);
    assign half_m1  = (half_bit == 16'd0) ? 16'd0 : half_bit - 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        if (!ctrl[1]) begin
            rx_state_n = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt_n   = half_m1;
                        rx_state_n = RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        // A high line at mid start bit was only a glitch.
                        if (rx_sync) begin
                            rx_state_n = RX_IDLE;
                        end else begin
                            rx_cnt_n   = div;
                            rx_bit_n   = 3'd0;
                            rx_state_n = RX_DATA;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift_n = {rx_sync, rx_shift[7:1]};
                        rx_cnt_n   = div;
                        if (rx_bit == 3'd7) begin
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_done    = rx_sync;
                        rx_ferr    = !rx_sync;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_cnt_n = rx_cnt - 16'd1;
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control/status registers; hardware set events win over clears
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            div     <= DIV_RESET;
            rx_hold <= '0;
            rxc     <= 1'b0;
            rxovf   <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= io_wdata[3:0] & CTRL_MASK;
            end
            if (wr_divl) begin
                div[7:0] <= io_wdata;
            end
            if (wr_divh) begin
                div[15:8] <= io_wdata;
            end
            if (rx_done) begin
                rx_hold <= rx_shift;
                rxc     <= 1'b1;
            end else if (rd_data) begin
                rxc <= 1'b0;
            end
            if (rx_done && rxc) begin
                rxovf <= 1'b1;
            end else if (wr_status && io_wdata[3]) begin
                rxovf <= 1'b0;
            end
            if (rx_ferr) begin
                ferr <= 1'b1;
            end else if (wr_status && io_wdata[4]) begin
                ferr <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            3'd0:    rd_mux = rx_hold;
            3'd1:    rd_mux = {3'b000, ferr, rxovf, rxc, fifo_full, txe};
            3'd2:    rd_mux = {4'b0000, ctrl};
            3'd3:    rd_mux = div[7:0];
            3'd4:    rd_mux = div[15:8];
            default: rd_mux = 8'h00;
        endcase
    end

    assign io_rdata = (io_re && addr_hit) ? rd_mux : 8'bzzzz_zzzz;

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef IO_UART_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (rxc && ctrl[2]) || (txe && ctrl[3]);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart at DIV=3: register reset values, TX framing and FIFO overflow,
// RX receive/overrun/framing error/false start, optional IRQ, and reset mid-frame.
module tb_io_uart;
  localparam logic [5:0] BASE = 6'h08;
  localparam int BIT = 4;
  localparam logic [2:0] R_DATA = 3'd0;
  localparam logic [2:0] R_STAT = 3'd1;
  localparam logic [2:0] R_CTRL = 3'd2;
  localparam logic [2:0] R_DIVL = 3'd3;
  localparam logic [2:0] R_DIVH = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] io_addr = 6'h00;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [7:0] io_wdata = 8'h00;
  wire  [7:0] io_rdata;
  logic       rxd = 1'b1;
  wire        txd;
  wire        irq;

  int n_asserts = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  io_uart dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_re(io_re), .io_we(io_we),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .rxd(rxd), .txd(txd), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called at posedge+1)
  task automatic io_write(input logic [2:0] off, input logic [7:0] d);
    io_addr = BASE + {3'b000, off};
    io_wdata = d;
    io_we = 1'b1;
    @(posedge clk); #1;
    io_we = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] off, output logic [7:0] d);
    io_addr = BASE + {3'b000, off};
    io_re = 1'b1;
    #2;
    d = io_rdata;
    @(posedge clk); #1;
    io_re = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] d;
    io_read(off, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic check_rx_data(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    io_read(R_DATA, d);
    check(tag, {8'h00, d}, {8'h00, e});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) rx_q.push_back(b);
    rxd = 1'b0;
    repeat (BIT) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(posedge clk); #1;
    end
    rxd = stop_bit;
    repeat (BIT) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  // TX scoreboard: decode each frame at mid-bit and compare with the queue head
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        @(negedge clk);
        check("tx_start_bit", {15'd0, txd}, 16'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        check("tx_stop_bit", {15'd0, txd}, 16'd1);
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        check("tx_frame_byte", {8'h00, b}, {8'h00, e});
      end
    end
  end

  initial begin
    logic [7:0] d;

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    check("reset_txd", {15'd0, txd}, 16'd1);
    check("reset_irq", {15'd0, irq}, 16'd0);
    check_reg("reset_status", R_STAT, 8'h01);
    check_reg("reset_divl", R_DIVL, 8'hB1);
    check_reg("reset_divh", R_DIVH, 8'h01);
    check_reg("reset_ctrl", R_CTRL, 8'h00);
    mon_en = 1'b1;

    // configure DIV=3, TXEN|RXEN
    io_write(R_DIVL, 8'h03);
    io_write(R_DIVH, 8'h00);
    io_write(R_CTRL, 8'h03);
    check_reg("ctrl_readback", R_CTRL, 8'h03);
    check_reg("divl_readback", R_DIVL, 8'h03);

    // TX single byte with exact timing
    tx_q.push_back(8'hA5);
    io_write(R_DATA, 8'hA5);
    check("tx_idle_at_push", {15'd0, txd}, 16'd1);
    @(posedge clk); #1;
    check("tx_low_after_load", {15'd0, txd}, 16'd0);
    repeat (39) @(posedge clk); #1;
    check_reg("txe_last_stop_clock", R_STAT, 8'h00);
    check_reg("txe_after_frame", R_STAT, 8'h01);

    // FIFO full with TXEN off
    io_write(R_CTRL, 8'h02);
    tx_q.push_back(8'h11); io_write(R_DATA, 8'h11);
    tx_q.push_back(8'h22); io_write(R_DATA, 8'h22);
    tx_q.push_back(8'h84); io_write(R_DATA, 8'h84);
    tx_q.push_back(8'hF0); io_write(R_DATA, 8'hF0);
    check_reg("fifo_full_status", R_STAT, 8'h02);
    io_write(R_DATA, 8'hEE);
    check_reg("fifo_full_after_drop", R_STAT, 8'h02);
    check("txd_held_txen_off", {15'd0, txd}, 16'd1);
    io_write(R_CTRL, 8'h03);
    repeat (4 * 10 * BIT + 20) @(posedge clk); #1;
    check_reg("fifo_drained_status", R_STAT, 8'h01);
    check("tx_queue_drained", 16'(tx_q.size()), 16'd0);

    // RX basic
    send_rx(8'h3C, 1'b1);
    check_reg("rxc_set", R_STAT, 8'h05);
    check_rx_data("rx_data_3c");
    check_reg("rxc_cleared", R_STAT, 8'h01);

    // RX overrun
    send_rx(8'h5A, 1'b1);
    send_rx(8'hC3, 1'b1);
    check_reg("rxovf_set", R_STAT, 8'h0D);
    while (rx_q.size() > 1) rx_q.delete(0);
    check_rx_data("rx_overwrite");
    check_reg("rxovf_sticky", R_STAT, 8'h09);
    io_write(R_STAT, 8'h18);
    check_reg("rxovf_cleared", R_STAT, 8'h01);

    // framing error leaves previous byte and RXC alone
    send_rx(8'h42, 1'b1);
    send_rx(8'h77, 1'b0);
    check_reg("ferr_set", R_STAT, 8'h15);
    check_rx_data("rx_after_ferr");
    check_reg("ferr_sticky", R_STAT, 8'h11);
    io_write(R_STAT, 8'h18);
    check_reg("ferr_cleared", R_STAT, 8'h01);

    // one-clock glitch: false start
    rxd = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (20) @(posedge clk); #1;
    check_reg("false_start_no_flags", R_STAT, 8'h01);
    send_rx(8'h6B, 1'b1);
    check_rx_data("rx_after_glitch");

`ifdef IO_UART_IRQ_EN
    io_write(R_CTRL, 8'h07);
    check("irq_idle", {15'd0, irq}, 16'd0);
    send_rx(8'h99, 1'b1);
    check("irq_on_rxc", {15'd0, irq}, 16'd1);
    check_rx_data("rx_irq_byte");
    check("irq_held_read_cycle", {15'd0, irq}, 16'd1);
    @(posedge clk); #1;
    check("irq_dropped", {15'd0, irq}, 16'd0);
`else
    io_write(R_CTRL, 8'h0F);
    check_reg("ctrl_ie_unimpl", R_CTRL, 8'h03);
    send_rx(8'h99, 1'b1);
    check("irq_tied_low", {15'd0, irq}, 16'd0);
    check_rx_data("rx_noirq_byte");
`endif

    // reset in the middle of a frame
    mon_en = 1'b0;
    io_write(R_CTRL, 8'h03);
    io_write(R_DATA, 8'h00);
    repeat (10) @(posedge clk); #1;
    check("midframe_txd_low", {15'd0, txd}, 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midframe_reset_txd", {15'd0, txd}, 16'd1);
    check_reg("midframe_reset_status", R_STAT, 8'h01);
    check_reg("midframe_reset_ctrl", R_CTRL, 8'h00);
    check_reg("midframe_reset_divl", R_DIVL, 8'hB1);
    repeat (50) @(posedge clk); #1;
    check("post_reset_txd_idle", {15'd0, txd}, 16'd1);
    check("rx_queue_drained", 16'(rx_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
